// File: rtl/alsu_pkg.sv
// Shared types and helpers for the pipelined ALSU.
// Opcode encoding, priority constants and the invalid-op rule.
package alsu_pkg;

   typedef enum logic [2:0] {
      OPC_AND    = 3'd0,
      OPC_XOR    = 3'd1,
      OPC_ADD    = 3'd2,
      OPC_MULT   = 3'd3,
      OPC_SHIFT  = 3'd4,
      OPC_ROTATE = 3'd5,
      OPC_INV6   = 3'd6,
      OPC_INV7   = 3'd7
   } opcode_e;

   localparam string PRIO_A = "A";
   localparam string PRIO_B = "B";

   function automatic logic is_invalid(
      input opcode_e opc,
      input logic    red_a,
      input logic    red_b
   );
      logic w_bad_opc;
      logic w_bad_red;
      w_bad_opc = (opc == OPC_INV6) || (opc == OPC_INV7);
      w_bad_red = (red_a || red_b) &&
                  (opc != OPC_AND) && (opc != OPC_XOR);
      return w_bad_opc || w_bad_red;
   endfunction

endpackage

// File: rtl/alsu_blink_ctrl.sv
// LED blink controller: starts on an error result, toggles the
// LEDs every BLINK_DIV cycles, and stops on a good result.
module alsu_blink_ctrl #(
   parameter int BLINK_DIV = 4,
   parameter int LED_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_err,
   input  logic             clear,
   output logic [LED_W-1:0] leds
);

   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] TOP = CW'(BLINK_DIV - 1);

   logic             r_act;
   logic [CW-1:0]    r_cnt;
   logic [LED_W-1:0] r_leds;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_act  <= 1'b0;
         r_cnt  <= '0;
         r_leds <= '0;
      end else if (clear) begin
         r_act  <= 1'b0;
         r_cnt  <= '0;
         r_leds <= '0;
      end else if (set_err && !r_act) begin
         r_act <= 1'b1;
         r_cnt <= '0;
      end else if (r_act) begin
         // a repeated error keeps counting instead of restarting
         if (r_cnt == TOP) begin
            r_cnt  <= '0;
            r_leds <= ~r_leds;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign leds = r_leds;

endmodule

// File: rtl/alsu_pipe.sv
// Two-stage pipelined ALSU: stage 1 registers the request,
// stage 2 evaluates it into the out register and drives the blinker.
module alsu_pipe
   import alsu_pkg::*;
#(
   parameter int    WIDTH          = 3,
   parameter string INPUT_PRIORITY = PRIO_A,
   parameter string FULL_ADDER     = "ON",
   parameter int    BLINK_DIV      = 4,
   parameter int    LED_W          = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 cin,
   input  logic                 serial_in,
   input  logic                 direction,
   input  logic                 red_op_A,
   input  logic                 red_op_B,
   input  logic                 bypass_A,
   input  logic                 bypass_B,
   input  logic [2:0]           opcode,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 out_valid,
   output logic [2*WIDTH-1:0]   out,
   output logic                 err,
   output logic [LED_W-1:0]     leds
);

   localparam int OUT_W     = 2 * WIDTH;
   localparam bit PRIO_IS_A = (INPUT_PRIORITY != PRIO_B);
   localparam bit ADD_CIN   = (FULL_ADDER == "ON");

   logic             r_v1;
   logic             r_cin;
   logic             r_si;
   logic             r_dir;
   logic             r_red_a;
   logic             r_red_b;
   logic             r_byp_a;
   logic             r_byp_b;
   opcode_e          r_opc;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;

   logic             r_ov;
   logic             r_err;
   logic [OUT_W-1:0] r_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1    <= 1'b0;
         r_cin   <= 1'b0;
         r_si    <= 1'b0;
         r_dir   <= 1'b0;
         r_red_a <= 1'b0;
         r_red_b <= 1'b0;
         r_byp_a <= 1'b0;
         r_byp_b <= 1'b0;
         r_opc   <= OPC_AND;
         r_a     <= '0;
         r_b     <= '0;
      end else begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_cin   <= cin;
            r_si    <= serial_in;
            r_dir   <= direction;
            r_red_a <= red_op_A;
            r_red_b <= red_op_B;
            r_byp_a <= bypass_A;
            r_byp_b <= bypass_B;
            r_opc   <= opcode_e'(opcode);
            r_a     <= A;
            r_b     <= B;
         end
      end
   end

   logic                    w_byp_any;
   logic                    w_byp_sel_a;
   logic                    w_red_any;
   logic                    w_red_sel_a;
   logic [WIDTH-1:0]        w_red_op;
   logic                    w_inv;
   logic [OUT_W-1:0]        w_sa;
   logic [OUT_W-1:0]        w_sb;
   logic [OUT_W-1:0]        w_sum;
   logic signed [OUT_W-1:0] w_prod;
   logic [OUT_W-1:0]        w_res;

   assign w_byp_any   = r_byp_a | r_byp_b;
   assign w_byp_sel_a = r_byp_a & (PRIO_IS_A | ~r_byp_b);
   assign w_red_any   = r_red_a | r_red_b;
   assign w_red_sel_a = r_red_a & (PRIO_IS_A | ~r_red_b);
   assign w_red_op    = w_red_sel_a ? r_a : r_b;
   assign w_inv       = ~w_byp_any & is_invalid(r_opc, r_red_a, r_red_b);

   assign w_sa   = {{WIDTH{r_a[WIDTH-1]}}, r_a};
   assign w_sb   = {{WIDTH{r_b[WIDTH-1]}}, r_b};
   assign w_sum  = w_sa + w_sb + OUT_W'(r_cin & ADD_CIN);
   assign w_prod = $signed(w_sa) * $signed(w_sb);

   always_comb begin
      w_res = '0;
      if (w_byp_any) begin
         w_res = w_byp_sel_a ? w_sa : w_sb;
      end else if (!w_inv) begin
         unique case (r_opc)
            OPC_AND:
               w_res = w_red_any ? OUT_W'(&w_red_op) : (w_sa & w_sb);
            OPC_XOR:
               w_res = w_red_any ? OUT_W'(^w_red_op) : (w_sa ^ w_sb);
            OPC_ADD:
               w_res = w_sum;
            OPC_MULT:
               w_res = w_prod;
            OPC_SHIFT:
               w_res = r_dir ? {r_out[OUT_W-2:0], r_si}
                             : {r_si, r_out[OUT_W-1:1]};
            OPC_ROTATE:
               w_res = r_dir ? {r_out[OUT_W-2:0], r_out[OUT_W-1]}
                             : {r_out[0], r_out[OUT_W-1:1]};
            OPC_INV6,
            OPC_INV7:
               w_res = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ov  <= 1'b0;
         r_err <= 1'b0;
         r_out <= '0;
      end else begin
         r_ov  <= r_v1;
         r_err <= r_v1 & w_inv;
         if (r_v1) r_out <= w_res;
      end
   end

   alsu_blink_ctrl #(
      .BLINK_DIV (BLINK_DIV),
      .LED_W     (LED_W)
   ) u_blink (
      .clk     (clk),
      .rst     (rst),
      .set_err (r_v1 & w_inv),
      .clear   (r_v1 & ~w_inv),
      .leds    (leds)
   );

   assign out_valid = r_ov;
   assign err       = r_err;
   assign out       = r_out;

endmodule

// File: tb/tb_alsu_pipe.sv
// Scoreboard bench for alsu_pipe: two instances with different
// priority/adder/blink settings share stimulus, checked against a model.
module tb_alsu_pipe;

   typedef struct {
      logic [2:0] a;
      logic [2:0] b;
      logic [2:0] opc;
      bit cin;
      bit si;
      bit dir;
      bit ra;
      bit rb;
      bit ba;
      bit bb;
   } tx_t;

   typedef struct {
      logic [5:0] o0;
      logic [5:0] o1;
      bit         e;
      int         due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic cin = 1'b0;
   logic serial_in = 1'b0;
   logic direction = 1'b0;
   logic red_op_A = 1'b0;
   logic red_op_B = 1'b0;
   logic bypass_A = 1'b0;
   logic bypass_B = 1'b0;
   logic [2:0] opcode = 3'd0;
   logic [2:0] A = 3'd0;
   logic [2:0] B = 3'd0;

   logic        ov0, ov1;
   logic        err0, err1;
   logic [5:0]  out0, out1;
   logic [15:0] leds0, leds1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t q[$];
   logic [5:0] m_out0 = 6'd0;
   logic [5:0] m_out1 = 6'd0;
   bit b_act[2];
   int b_cnt[2];
   int b_div[2] = '{4, 1};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alsu_pipe #(
      .WIDTH(3), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"),
      .BLINK_DIV(4), .LED_W(16)
   ) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .cin(cin),
      .serial_in(serial_in), .direction(direction),
      .red_op_A(red_op_A), .red_op_B(red_op_B),
      .bypass_A(bypass_A), .bypass_B(bypass_B),
      .opcode(opcode), .A(A), .B(B),
      .out_valid(ov0), .out(out0), .err(err0), .leds(leds0)
   );

   alsu_pipe #(
      .WIDTH(3), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"),
      .BLINK_DIV(1), .LED_W(16)
   ) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .cin(cin),
      .serial_in(serial_in), .direction(direction),
      .red_op_A(red_op_A), .red_op_B(red_op_B),
      .bypass_A(bypass_A), .bypass_B(bypass_B),
      .opcode(opcode), .A(A), .B(B),
      .out_valid(ov1), .out(out1), .err(err1), .leds(leds1)
   );

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Result as a number: operands are signed ints, out is taken mod 64.
   function automatic logic [6:0] ref_model(
      tx_t t, bit prio_a, bit fa, logic [5:0] prev
   );
      int a, b, p, r;
      bit e;
      logic [2:0] sel;
      a = $signed(t.a);
      b = $signed(t.b);
      p = int'(prev);
      e = 0;
      r = 0;
      sel = (t.ra && (prio_a || !t.rb)) ? t.a : t.b;
      if (t.ba || t.bb) begin
         r = (t.ba && (prio_a || !t.bb)) ? a : b;
      end else if (t.opc >= 6 || ((t.ra || t.rb) && t.opc >= 2)) begin
         e = 1;
      end else begin
         case (t.opc)
            3'd0: r = (t.ra || t.rb) ? int'(sel == 3'b111) : (a & b);
            3'd1: r = (t.ra || t.rb) ? ($countones(sel) % 2) : (a ^ b);
            3'd2: r = a + b + (fa ? int'(t.cin) : 0);
            3'd3: r = a * b;
            3'd4: r = t.dir ? (2 * p + int'(t.si)) : (p / 2 + 32 * int'(t.si));
            default: r = t.dir ? (2 * p + p / 32) : (p / 2 + 32 * (p % 2));
         endcase
      end
      return {e, 6'(r)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(tx_t t);
      exp_t x;
      logic [6:0] r0, r1;
      step();
      in_valid = 1'b1;
      A = t.a; B = t.b; opcode = t.opc;
      cin = t.cin; serial_in = t.si; direction = t.dir;
      red_op_A = t.ra; red_op_B = t.rb;
      bypass_A = t.ba; bypass_B = t.bb;
      r0 = ref_model(t, 1'b1, 1'b1, m_out0);
      r1 = ref_model(t, 1'b0, 1'b0, m_out1);
      m_out0 = r0[5:0];
      m_out1 = r1[5:0];
      x.o0 = r0[5:0];
      x.o1 = r1[5:0];
      x.e = r0[6];
      x.due = cyc + 2;
      q.push_back(x);
   endtask

   task automatic idle();
      step();
      in_valid = 1'b0;
      A = 3'($urandom); B = 3'($urandom); opcode = 3'($urandom);
      cin = 1'($urandom); serial_in = 1'($urandom);
      bypass_A = 1'($urandom); red_op_A = 1'($urandom);
   endtask

   function automatic tx_t mk(logic [2:0] opc, logic [2:0] a, logic [2:0] b);
      tx_t t;
      t.a = a; t.b = b; t.opc = opc;
      t.cin = 0; t.si = 0; t.dir = 0;
      t.ra = 0; t.rb = 0; t.ba = 0; t.bb = 0;
      return t;
   endfunction

   function automatic tx_t rnd_tx();
      tx_t t;
      t.a = 3'($urandom); t.b = 3'($urandom);
      t.opc = 3'($urandom);
      t.cin = 1'($urandom); t.si = 1'($urandom); t.dir = 1'($urandom);
      t.ra = ($urandom_range(0, 5) == 0);
      t.rb = ($urandom_range(0, 5) == 0);
      t.ba = ($urandom_range(0, 7) == 0);
      t.bb = ($urandom_range(0, 7) == 0);
      return t;
   endfunction

   function automatic int exp_leds(int k);
      return (b_act[k] && ((b_cnt[k] / b_div[k]) % 2 == 1)) ? 16'hFFFF : 0;
   endfunction

   // Monitor: pops the scoreboard when a result is due, tracks blinking.
   always @(negedge clk) begin
      exp_t x;
      bit has;
      has = 0;
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            b_act[k] = 0;
            b_cnt[k] = 0;
         end
      end else begin
         if (q.size() > 0 && q[0].due <= cyc) begin
            x = q.pop_front();
            has = 1;
         end
         chk("out_valid0", int'(ov0), int'(has));
         chk("out_valid1", int'(ov1), int'(has));
         chk("err0", int'(err0), has ? int'(x.e) : 0);
         chk("err1", int'(err1), has ? int'(x.e) : 0);
         if (has) begin
            chk("out0", int'(out0), int'(x.o0));
            chk("out1", int'(out1), int'(x.o1));
         end
         for (int k = 0; k < 2; k++) begin
            if (has && !x.e) begin
               b_act[k] = 0;
               b_cnt[k] = 0;
            end else if (has && x.e && !b_act[k]) begin
               b_act[k] = 1;
               b_cnt[k] = 0;
            end else if (b_act[k]) begin
               b_cnt[k]++;
            end
         end
         chk("leds0", int'(leds0), exp_leds(0));
         chk("leds1", int'(leds1), exp_leds(1));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      tx_t t;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out0", int'(out0), 0);
      chk("rst_valid0", int'(ov0), 0);
      chk("rst_err0", int'(err0), 0);
      chk("rst_leds0", int'(leds0), 0);
      chk("rst_out1", int'(out1), 0);
      chk("rst_leds1", int'(leds1), 0);
      rst = 1'b0;

      // ADD 3 + -2 + cin
      t = mk(3'd2, 3'd3, 3'b110);
      t.cin = 1;
      issue(t);
      idle(); idle();

      // MULT then SHIFT left back-to-back
      issue(mk(3'd3, 3'd3, 3'b110));
      t = mk(3'd4, 3'd0, 3'd0);
      t.dir = 1; t.si = 1;
      issue(t);
      idle();

      // bypass both
      t = mk(3'd2, 3'b101, 3'd2);
      t.ba = 1; t.bb = 1;
      issue(t);
      idle();

      // invalid reduction on ADD, let it blink, then a good AND
      t = mk(3'd2, 3'd1, 3'd2);
      t.ra = 1;
      issue(t);
      repeat (10) idle();
      issue(mk(3'd0, 3'd3, 3'd1));
      idle(); idle();

      // reset while blinking with results in flight
      issue(mk(3'd7, 3'd1, 3'd1));
      repeat (4) idle();
      issue(mk(3'd6, 3'd2, 3'd3));
      issue(mk(3'd7, 3'd4, 3'd5));
      step();
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("arst_out0", int'(out0), 0);
      chk("arst_valid0", int'(ov0), 0);
      chk("arst_leds0", int'(leds0), 0);
      chk("arst_out1", int'(out1), 0);
      chk("arst_valid1", int'(ov1), 0);
      chk("arst_leds1", int'(leds1), 0);
      q.delete();
      m_out0 = 6'd0;
      m_out1 = 6'd0;
      step(); step();
      rst = 1'b0;
      repeat (3) idle();

      // 8 back-to-back ADDs
      for (int i = 0; i < 8; i++) begin
         t = mk(3'd2, 3'($urandom), 3'($urandom));
         t.cin = 1'($urandom);
         issue(t);
      end
      idle(); idle();

      // random mix with gaps
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         else issue(rnd_tx());
      end
      repeat (6) idle();
      chk("scoreboard_drained", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alsu_pipe.md
Name: alsu_pipe

Overview:
Parametrised, pipelined successor to the 3-bit ALSU. Operand width is configurable, and a valid-qualified two-stage pipeline sustains one result per clock. Invalid operations drive the LEDs with a timed blink rather than a static pattern. The block sits behind the alu_if-style stimulus interface and drives out and leds toward the board and the scoreboard.

Parameters:
WIDTH, 3, signed operand width of A and B; OUT_W = 2*WIDTH.
INPUT_PRIORITY, "A", which of A or B wins when both bypass or both red_op flags are set ("A" or "B").
FULL_ADDER, "ON", "ON" adds cin in the ADD operation; "OFF" ignores cin.
BLINK_DIV, 4, clock cycles between LED toggles while blinking; must be at least 1.
LED_W, 16, LED bus width.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  qualifies all operand and control inputs this cycle.
cin  in  1  carry-in for ADD.
serial_in  in  1  shift-in bit for SHIFT.
direction  in  1  1 = left, 0 = right, for SHIFT and ROTATE.
red_op_A, red_op_B  in  1 each  reduction select.
bypass_A, bypass_B  in  1 each  pass operand through to out.
opcode  in  3  operation select.
A, B  in  WIDTH  signed operands.
out_valid  out  1  out was updated this cycle.
out  out  OUT_W  result register.
err  out  1  high with out_valid when that result was an invalid operation.
leds  out  LED_W  blink pattern.

Behaviour:
- Reset (async, rst=1) clears everything immediately: stage-1 registers 0, out=0, out_valid=0, err=0, leds=0, blink inactive, blink counter 0. This applies mid-pipeline and mid-blink; in-flight data is discarded.
- Stage 1, every clk:
  - v1 <= in_valid.
  - When in_valid=1, capture all inputs into stage-1 registers.
  - When in_valid=0, stage-1 registers hold.
- Stage 2, every clk:
  - out_valid <= v1 and err <= (v1 and invalid).
  - out updates only when v1=1; otherwise out holds.
- Latency: 2 cycles from in_valid to out_valid. Back-to-back inputs give back-to-back outputs with no bubbles.
- Evaluation priority, highest first:
  1. Bypass: if both bypass bits are set, INPUT_PRIORITY selects. out = sign-extended operand.
  2. Invalid: opcode 110 or 111, or (red_op_A or red_op_B) with opcode not 000/001. out = 0, err = 1.
  3. Opcode decode.
- Opcode operations:
  - 000 AND: out = sext(A & B). If a red_op flag is set, out = zero-extended reduction-AND of the selected operand; INPUT_PRIORITY breaks ties.
  - 001 XOR: out = sext(A ^ B), or the reduction-XOR analogue of 000.
  - 010 ADD: out = sext(A) + sext(B) + (FULL_ADDER=="ON" ? cin : 0), modulo 2^OUT_W.
  - 011 MULT: out = signed A*B. The product is exact in OUT_W bits.
  - 100 SHIFT: operates on the current out register. Left: {out[OUT_W-2:0], serial_in}. Right: {serial_in, out[OUT_W-1:1]}.
  - 101 ROTATE: operates on the current out register. Left: {out[OUT_W-2:0], out[OUT_W-1]}. Right: {out[0], out[OUT_W-1:1]}.
- SHIFT and ROTATE operate on the out value as of the cycle they reach stage 2. That value includes a result committed by the immediately preceding cycle, so no hazard exists.
- Blink controller:
  - Any result with err=1 sets blink active if it is not already active, with counter <= 0 and leds unchanged.
  - While active, counter increments every clk. At BLINK_DIV-1 it wraps to 0 and leds <= ~leds.
  - A further invalid result while blinking does not restart the counter.
  - Any valid non-invalid result (including bypass) clears blink in the same edge: leds <= 0, counter <= 0.
  - Blink continues regardless of in_valid.

Decomposition:
- Package alsu_pkg holds:
  - opcode enum (OPC_AND=0, OPC_XOR, OPC_ADD, OPC_MULT, OPC_SHIFT, OPC_ROTATE, OPC_INV6, OPC_INV7);
  - function is_invalid(opcode, red_A, red_B);
  - priority string constants "A"/"B".
- One sub-module, alsu_blink_ctrl (params BLINK_DIV, LED_W; inputs set_err, clear; output leds). It owns the counter and the blink state.

Test Plan (all with WIDTH=3, OUT_W=6):
- ADD: A=3, B=-2, cin=1, FULL_ADDER="ON", in_valid for 1 cycle -> out_valid high 2 cycles later, out=6'b000010, err=0. With FULL_ADDER="OFF" -> out=6'b000001.
- MULT then SHIFT back-to-back: MULT A=3, B=-2, then next cycle opcode=100, direction=1, serial_in=1 -> out=6'b111010, then out=6'b110101 on consecutive cycles.
- Bypass: bypass_A=bypass_B=1, A=-3, B=2, INPUT_PRIORITY="A" -> out=6'b111101. With INPUT_PRIORITY="B" -> out=6'b000010.
- Invalid: red_op_A=1 with opcode=010 -> out=0, err=1. leds=16'hFFFF BLINK_DIV=4 cycles later and 16'h0000 4 cycles after that. A following valid AND A=3, B=1 -> out=6'b000001, leds=0 at that edge.
- Reset mid-operation: assert rst asynchronously while blinking and with a result in flight -> leds=0, out=0, out_valid=0 immediately; no stale out_valid after release.
- Throughput: 8 consecutive in_valid ADDs with random operands -> 8 consecutive out_valid cycles, each matching the reference model, no gaps.
